// File: rtl/lif_pkg.sv
// ============================================================================
// Module   : lif_pkg
// Brief    : Shared types and constants for the LIF neuron TDM scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lif_pkg;

    localparam int STATE_W = 8;
    localparam logic [STATE_W-1:0] DEFAULT_THRESH = 8'd230;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } fsm_t;

endpackage

`default_nettype wire

// File: rtl/lif_update.sv
// ============================================================================
// Module   : lif_update
// Brief    : Combinational leaky integrate-and-fire update for one neuron.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lif_update
    import lif_pkg::*;
#(
    parameter int CUR_W = 8
) (
    input  logic [STATE_W-1:0] s,
    input  logic [CUR_W-1:0]   c,
    input  logic [STATE_W-1:0] th,
    output logic [STATE_W-1:0] next,
    output logic               spike
);

    localparam int SUM_W = STATE_W + 1;

    logic [SUM_W-1:0] w_sum;

    // Leak keeps s/2 + s/4 + s/8; the 9-bit sum cannot wrap for 8-bit operands.
    always_comb begin
        spike = (s >= th);
        w_sum = SUM_W'(c) + SUM_W'(s >> 1) + SUM_W'(s >> 2) + SUM_W'(s >> 3);
        if (spike) begin
            next = '0;
        end else if (w_sum[SUM_W-1]) begin
            next = '1;
        end else begin
            next = w_sum[STATE_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/lif_tdm_scheduler.sv
// ============================================================================
// Module   : lif_tdm_scheduler
// Brief    : Sweeps one shared LIF datapath over N neurons per timestep tick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lif_tdm_scheduler
    import lif_pkg::*;
#(
    parameter int N     = 8,
    parameter int CUR_W = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [N*CUR_W-1:0]   cur_in,
    input  logic                 cfg_we,
    input  logic [STATE_W-1:0]   cfg_thresh,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [STATE_W-1:0]   rd_state,
    output logic                 busy,
    output logic [N-1:0]         spike_out,
    output logic                 spike_valid,
    output logic                 overrun,
    output logic [STATE_W-1:0]   threshold
);

    fsm_t               r_fsm;
    fsm_t               w_fsm_next;
    logic               w_accept;
    logic               w_last;

    logic [IDX_W-1:0]   r_idx;
    logic [CUR_W-1:0]   r_cur [N];
    logic [STATE_W-1:0] r_state [N];
    logic [N-1:0]       r_spike_acc;
    logic [N-1:0]       w_spike_vec;
    logic [N-1:0]       r_spike_out;
    logic               r_spike_valid;
    logic               r_overrun;
    logic [STATE_W-1:0] r_threshold;
    logic [STATE_W-1:0] r_pend_thresh;
    logic               r_pend_valid;
    logic [STATE_W-1:0] r_rd_state;

    logic [STATE_W-1:0] w_next;
    logic               w_spike;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        w_accept   = 1'b0;
        w_last     = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (tick) begin
                    w_accept   = 1'b1;
                    w_fsm_next = SWEEP;
                end
            end
            SWEEP: begin
                if (r_idx == IDX_W'(N - 1)) begin
                    w_last     = 1'b1;
                    w_fsm_next = IDLE;
                end
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    lif_update #(
        .CUR_W (CUR_W)
    ) u_update (
        .s     (r_state[r_idx]),
        .c     (r_cur[r_idx]),
        .th    (r_threshold),
        .next  (w_next),
        .spike (w_spike)
    );

    // The final neuron's spike is merged in directly so spike_out lands with the last update.
    always_comb begin
        w_spike_vec        = r_spike_acc;
        w_spike_vec[r_idx] = w_spike;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx         <= '0;
            r_spike_acc   <= '0;
            r_spike_out   <= '0;
            r_spike_valid <= 1'b0;
            r_overrun     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_cur[i]   <= '0;
                r_state[i] <= '0;
            end
        end else begin
            r_spike_valid <= w_last;
            if (w_accept) begin
                for (int i = 0; i < N; i++) begin
                    r_cur[i] <= cur_in[i*CUR_W +: CUR_W];
                end
                r_idx       <= '0;
                r_spike_acc <= '0;
            end else if (r_fsm == SWEEP) begin
                r_state[r_idx] <= w_next;
                r_spike_acc    <= w_spike_vec;
                if (w_last) begin
                    r_spike_out <= w_spike_vec;
                    r_idx       <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (tick && (r_fsm == SWEEP)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Writes during a sweep are parked so every neuron in a sweep sees one threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_threshold   <= DEFAULT_THRESH;
            r_pend_thresh <= '0;
            r_pend_valid  <= 1'b0;
        end else if (r_fsm == IDLE) begin
            if (cfg_we) begin
                r_threshold <= cfg_thresh;
            end else if (r_pend_valid) begin
                r_threshold <= r_pend_thresh;
            end
            r_pend_valid <= 1'b0;
        end else if (cfg_we) begin
            r_pend_thresh <= cfg_thresh;
            r_pend_valid  <= 1'b1;
        end
    end

    generate
        if ((1 << IDX_W) == N) begin : g_rd_direct
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_state <= '0;
                end else begin
                    r_rd_state <= r_state[rd_idx];
                end
            end
        end else begin : g_rd_guarded
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_state <= '0;
                end else if (int'(rd_idx) < N) begin
                    r_rd_state <= r_state[rd_idx];
                end else begin
                    r_rd_state <= '0;
                end
            end
        end
    endgenerate

    assign rd_state    = r_rd_state;
    assign busy        = (r_fsm == SWEEP);
    assign spike_out   = r_spike_out;
    assign spike_valid = r_spike_valid;
    assign overrun     = r_overrun;
    assign threshold   = r_threshold;

endmodule

`default_nettype wire

// File: tb/tb_lif_tdm_scheduler.sv
// ============================================================================
// Module   : tb_lif_tdm_scheduler
// Brief    : Directed and randomized self-checking bench for lif_tdm_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lif_tdm_scheduler;

    localparam int N     = 8;
    localparam int CUR_W = 8;
    localparam int IDX_W = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tick = 1'b0;
    logic [N*CUR_W-1:0] cur_in = '0;
    logic               cfg_we = 1'b0;
    logic [7:0]         cfg_thresh = '0;
    logic [IDX_W-1:0]   rd_idx = '0;
    logic [7:0]         rd_state;
    logic               busy;
    logic [N-1:0]       spike_out;
    logic               spike_valid;
    logic               overrun;
    logic [7:0]         threshold;

    lif_tdm_scheduler #(
        .N     (N),
        .CUR_W (CUR_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .cur_in      (cur_in),
        .cfg_we      (cfg_we),
        .cfg_thresh  (cfg_thresh),
        .rd_idx      (rd_idx),
        .rd_state    (rd_state),
        .busy        (busy),
        .spike_out   (spike_out),
        .spike_valid (spike_valid),
        .overrun     (overrun),
        .threshold   (threshold)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: membrane values, active threshold and sticky overrun.
    int m_state [N];
    int m_thr;
    bit m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*CUR_W-1:0] rand_cur();
        logic [N*CUR_W-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*CUR_W +: CUR_W] = CUR_W'($urandom_range(0, (1 << CUR_W) - 1));
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_state[i] = 0;
        m_thr = 230;
        m_ovr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " spike_out"}, spike_out, 0);
        check({tag, " spike_valid"}, spike_valid, 0);
        check({tag, " overrun"}, overrun, 0);
        check({tag, " threshold"}, threshold, 230);
        check({tag, " rd_state"}, rd_state, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic readback_all(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_idx = IDX_W'(i);
            step();
            check($sformatf("%s rd_state[%0d]", tag, i), rd_state, m_state[i]);
        end
    endtask

    // One full sweep. extra_j: cycle offset of a second tick (-1 none);
    // cfg_j: cycle offset of a threshold write (-1 none, 0 = with the tick).
    task automatic sweep(input string tag, input logic [N*CUR_W-1:0] cur,
                         input int extra_j, input int cfg_j, input logic [7:0] cfg_val);
        logic [N-1:0] exp_spk;
        int           thr_old;
        int           thr_new;
        int           c;
        int           nv;
        if (cfg_j == 0) m_thr = cfg_val;
        thr_old = m_thr;
        for (int k = 0; k < N; k++) begin
            c = int'(cur[k*CUR_W +: CUR_W]);
            exp_spk[k] = (m_state[k] >= m_thr);
            if (exp_spk[k]) begin
                m_state[k] = 0;
            end else begin
                nv = c + m_state[k] / 2 + m_state[k] / 4 + m_state[k] / 8;
                m_state[k] = (nv > 255) ? 255 : nv;
            end
        end
        thr_new = (cfg_j >= 1) ? int'(cfg_val) : m_thr;
        for (int j = 1; j <= N + 2; j++) begin
            tick       = (j == 1) || (j - 1 == extra_j);
            cur_in     = (j == 1) ? cur : rand_cur();
            cfg_we     = (j - 1 == cfg_j);
            cfg_thresh = cfg_val;
            if (j > 1 && j - 1 == extra_j) m_ovr = 1'b1;
            step();
            check($sformatf("%s busy@%0d", tag, j), busy, (j <= N) ? 1 : 0);
            check($sformatf("%s spike_valid@%0d", tag, j), spike_valid, (j == N + 1) ? 1 : 0);
            check($sformatf("%s overrun@%0d", tag, j), overrun, m_ovr);
            if (j == N + 1) check({tag, " spike_out"}, spike_out, exp_spk);
            if (cfg_j >= 1 && j <= N) check($sformatf("%s thr_hold@%0d", tag, j), threshold, thr_old);
        end
        tick   = 1'b0;
        cfg_we = 1'b0;
        m_thr  = thr_new;
        check({tag, " threshold_after"}, threshold, m_thr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*CUR_W-1:0] cur3;
        int                 cj;
        model_reset();
        cur3 = '0;
        cur3[3*CUR_W +: CUR_W] = 8'd100;

        // Reset state, then an all-zero sweep, then a tick in the last busy cycle.
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        sweep("zero", '0, -1, -1, 8'd0);
        sweep("late_tick", '0, N, -1, 8'd0);
        pulse_reset();
        check_reset_outputs("reset2");

        // Constant drive on neuron 3: 100, 187, 255 (saturated), then spike.
        for (int s = 1; s <= 4; s++) begin
            sweep($sformatf("n3_sweep%0d", s), cur3, -1, -1, 8'd0);
            readback_all($sformatf("n3_sweep%0d", s));
        end

        // Second tick three cycles in: overrun sticks, sweep still completes once.
        sweep("overrun", cur3, 3, -1, 8'd0);
        sweep("overrun_hold", cur3, -1, -1, 8'd0);

        // Mid-sweep threshold write, deferred until the sweep ends.
        pulse_reset();
        sweep("cfg_sweep1", cur3, -1, 4, 8'd150);
        sweep("cfg_sweep2", cur3, -1, -1, 8'd0);
        sweep("cfg_sweep3", cur3, -1, -1, 8'd0);
        readback_all("cfg");

        // Randomized sweeps with threshold writes at random offsets, including with the tick.
        for (int r = 0; r < 8; r++) begin
            cj = (r % 3 == 2) ? -1 : int'($urandom_range(0, N));
            sweep($sformatf("rand%0d", r), rand_cur(), -1, cj, 8'($urandom_range(60, 255)));
            readback_all($sformatf("rand%0d", r));
        end

        // Asynchronous reset while neuron 4 is being updated.
        tick   = 1'b1;
        cur_in = rand_cur();
        step();
        tick = 1'b0;
        for (int j = 0; j < 4; j++) step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_rst");
        step();
        rst_n = 1'b1;
        for (int j = 0; j < N + 2; j++) begin
            step();
            check($sformatf("post_rst spike_valid@%0d", j), spike_valid, 0);
        end
        readback_all("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
